// File: rtl/kv_wb_master_if.sv
// kv_wb_master_if: bundles the host command/response channel and the store bus.
// Latency: none, wires only.
// Backpressure: cmd_ready_o / rsp_ready_i valid-ready pairs; the store answers with ACK_i.
interface kv_wb_master_if #(
    parameter int DW = 16
);
    // host command channel
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_we_i;
    logic [DW-1:0] cmd_adr_i;
    logic [DW-1:0] cmd_key_i;
    logic [DW-1:0] cmd_dat_i;
    // host response channel
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_dat_o;
    logic          rsp_err_o;
    // store bus
    logic          CYC_o;
    logic          STB_o;
    logic          WE_o;
    logic [DW-1:0] ADR_o;
    logic [DW-1:0] DAT_o;
    logic [DW-1:0] KEY_o;
    logic          RESET_o;
    logic          ACK_i;
    logic [DW-1:0] DAT_i;

    // sequencer side
    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_key_i, cmd_dat_i, rsp_ready_i, ACK_i, DAT_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
               CYC_o, STB_o, WE_o, ADR_o, DAT_o, KEY_o, RESET_o
    );

    // host + store side
    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_key_i, cmd_dat_i, rsp_ready_i, ACK_i, DAT_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
               CYC_o, STB_o, WE_o, ADR_o, DAT_o, KEY_o, RESET_o
    );
endinterface

// File: rtl/kv_wb_master.sv
// kv_wb_master: turns host insert/update/lookup commands into key-value store bus cycles.
// Latency: write 3 cycles accept->response (ACK in first WAIT cycle), lookup 3+HOLD_CYCLES.
// Backpressure: one transaction outstanding; cmd_ready_o stays low until the response is taken.
// Optional hit/timeout counters are built when KV_MASTER_STATS_EN is defined.
module kv_wb_master #(
    parameter int DW          = 16,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
`ifdef KV_MASTER_STATS_EN
    output logic [DW-1:0] stat_ok_o,
    output logic [DW-1:0] stat_to_o,
`endif
    kv_wb_master_if.master bus
);
    localparam int             TW        = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]  TMAX      = TW'(TIMEOUT - 1);
    localparam logic [3:0]     HOLD_INIT = 4'(HOLD_CYCLES);

    typedef enum logic [2:0] {IDLE, ISSUE, HOLD, WAIT, RESP} state_t;

    state_t        state_q,     state_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic [3:0]    hold_q,      hold_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q,   rsp_err_d;
    logic [DW-1:0] rsp_dat_q,   rsp_dat_d;
    logic          cyc_q,       cyc_d;
    logic          stb_q,       stb_d;
    logic          we_q,        we_d;
    logic [DW-1:0] adr_q,       adr_d;
    logic [DW-1:0] dat_q,       dat_d;
    logic [DW-1:0] key_q,       key_d;
    logic          reset_q,     reset_d;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        hold_d      = hold_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        key_d       = key_q;
        reset_d     = 1'b0;   // recovery pulse is only ever one cycle wide

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid_i && cmd_ready_q) begin
                    we_d        = bus.cmd_we_i;
                    adr_d       = bus.cmd_adr_i;
                    key_d       = bus.cmd_key_i;
                    dat_d       = bus.cmd_dat_i;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                stb_d = 1'b0;
                if (we_q) begin
                    timer_d = '0;
                    state_d = WAIT;
                end else begin
                    hold_d  = HOLD_INIT;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // lookups keep CYC up with STB low so the store can resolve the key
                if (hold_q <= 4'd1) begin
                    cyc_d   = 1'b0;
                    timer_d = '0;
                    state_d = WAIT;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            WAIT: begin
                // ACK takes priority over a coincident timeout
                if (bus.ACK_i) begin
                    rsp_dat_d   = bus.DAT_i;
                    rsp_err_d   = 1'b0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (timer_q == TMAX) begin
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    cyc_d       = 1'b0;
                    reset_d     = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            hold_q      <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            key_q       <= '0;
            reset_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            hold_q      <= hold_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            key_q       <= key_d;
            reset_q     <= reset_d;
        end
    end

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.CYC_o       = cyc_q;
    assign bus.STB_o       = stb_q;
    assign bus.WE_o        = we_q;
    assign bus.ADR_o       = adr_q;
    assign bus.DAT_o       = dat_q;
    assign bus.KEY_o       = key_q;
    assign bus.RESET_o     = reset_q;

`ifdef KV_MASTER_STATS_EN
    logic [DW-1:0] ok_q;
    logic [DW-1:0] to_q;

    // Saturating completion counters, bumped on the cycle RESP is entered.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ok_q <= '0;
            to_q <= '0;
        end else if (state_q == WAIT && state_d == RESP) begin
            if (rsp_err_d) begin
                if (to_q != '1) to_q <= to_q + 1'b1;
            end else begin
                if (ok_q != '1) ok_q <= ok_q + 1'b1;
            end
        end
    end

    assign stat_ok_o = ok_q;
    assign stat_to_o = to_q;
`endif
endmodule

// File: tb/tb_kv_wb_master.sv
// tb_kv_wb_master: directed commands with a scoreboard of expected responses.
// Latency: measured against the clock-cycle counter.
// Backpressure: exercised by holding rsp_ready_i low with a queued command.
module tb_kv_wb_master;
    localparam int DW = 16;

    logic sys_clk;
    logic sys_rst;
    kv_wb_master_if #(.DW(DW)) bus ();
`ifdef KV_MASTER_STATS_EN
    logic [DW-1:0] stat_ok;
    logic [DW-1:0] stat_to;
`endif

    kv_wb_master #(.DW(DW), .HOLD_CYCLES(2), .TIMEOUT(64)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
`ifdef KV_MASTER_STATS_EN
        .stat_ok_o (stat_ok),
        .stat_to_o (stat_to),
`endif
        .bus     (bus.master)
    );

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];           // {err, dat}

    int ncyc = 0;                    // current cycle index, bumped at posedge
    int cyc_tot = 0, stb_tot = 0, rst_tot = 0, rst_cyc = 0;
    int rise_cyc = 0, hs_cnt = 0, hs_cyc = 0;
    logic [15:0] stb_adr, stb_key, stb_dat, rise_adr, rise_key;
    logic        stb_we, rise_we, rv_prev;
    logic [16:0] e;

    int          ack_at = -1;        // cycles after the STB cycle at which the store ACKs
    logic [15:0] store_dat = '0;
    bit          stray_ack = 1'b0;
    int          st_cnt = -1;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial forever begin
        @(posedge sys_clk);
        ncyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Store model: answers a strobe with ACK after ack_at cycles.
    initial begin
        bus.ACK_i = 1'b0;
        bus.DAT_i = '0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst)            st_cnt = -1;
            else if (bus.STB_o)     st_cnt = 0;
            else if (st_cnt >= 0)   st_cnt++;
            bus.ACK_i = stray_ack || (st_cnt >= 0 && st_cnt == ack_at);
            if (st_cnt >= 0 && st_cnt == ack_at) st_cnt = -1;
            bus.DAT_i = store_dat;
        end
    end

    // Monitor: bus activity counters and scoreboard compare on each response handshake.
    initial begin
        rv_prev = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (bus.CYC_o) cyc_tot++;
            if (bus.STB_o) begin
                stb_tot++;
                stb_adr = bus.ADR_o; stb_key = bus.KEY_o; stb_dat = bus.DAT_o; stb_we = bus.WE_o;
            end
            if (bus.RESET_o) begin rst_tot++; rst_cyc = ncyc; end
            if (bus.rsp_valid_o && !rv_prev) begin
                rise_cyc = ncyc; rise_adr = bus.ADR_o; rise_key = bus.KEY_o; rise_we = bus.WE_o;
            end
            rv_prev = bus.rsp_valid_o;
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                hs_cyc = ncyc;
                hs_cnt++;
                if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("rsp_dat", 32'(bus.rsp_dat_o), 32'(e[15:0]));
                    chk("rsp_err", 32'(bus.rsp_err_o), 32'(e[16]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [15:0] adr, input logic [15:0] key,
                         input logic [15:0] dat, output int acc);
        bus.cmd_we_i = we; bus.cmd_adr_i = adr; bus.cmd_key_i = key; bus.cmd_dat_i = dat;
        bus.cmd_valid_i = 1'b1;
        acc = -1;
        for (int i = 0; i < 50 && acc < 0; i++) begin
            if (bus.cmd_ready_o) acc = ncyc;
            tick();
        end
        bus.cmd_valid_i = 1'b0;
        if (acc < 0) chk("accept_wait", 32'd0, 32'd1);
    endtask

    task automatic wait_hs(input int n0);
        int i;
        for (i = 0; i < 300 && hs_cnt <= n0; i++) tick();
        if (hs_cnt <= n0) chk("rsp_wait", 32'd0, 32'd1);
    endtask

    initial begin
        int acc, acc_b, c0, s0, h0, r0;
        bit bad_rdy, bad_stab;
        bus.cmd_valid_i = 1'b0; bus.cmd_we_i = 1'b0;
        bus.cmd_adr_i = '0; bus.cmd_key_i = '0; bus.cmd_dat_i = '0;
        bus.rsp_ready_i = 1'b1;
        sys_rst = 1'b1;
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err_o),   32'd0);
        chk("rst_rsp_dat",   32'(bus.rsp_dat_o),   32'd0);
        chk("rst_bus_ctl",   32'({bus.CYC_o, bus.STB_o, bus.WE_o, bus.RESET_o}), 32'd0);
        chk("rst_bus_dat",   32'({bus.ADR_o, bus.DAT_o}), 32'd0);
        chk("rst_key",       32'(bus.KEY_o), 32'd0);
        sys_rst = 1'b0;
        tick();

        // insert into next free slot
        ack_at = 1; store_dat = 16'h0001;
        c0 = cyc_tot; s0 = stb_tot; h0 = hs_cnt;
        exp_q.push_back({1'b0, 16'h0001});
        issue(1'b1, 16'h0000, 16'h00AA, 16'h1234, acc);
        wait_hs(h0);
        chk("ins_cyc_len", 32'(cyc_tot - c0), 32'd2);
        chk("ins_stb_len", 32'(stb_tot - s0), 32'd1);
        chk("ins_latency", 32'(rise_cyc - acc), 32'd3);
        chk("ins_bus_fields", {stb_we, 15'(stb_adr), stb_key}, {1'b1, 15'h0000, 16'h00AA});
        chk("ins_wdat", 32'(stb_dat), 32'h1234);
        chk("ins_hold_fields", {rise_we, 15'(rise_adr), rise_key}, {1'b1, 15'h0000, 16'h00AA});

        // lookup slot 3
        ack_at = 3; store_dat = 16'hBEEF;
        c0 = cyc_tot; s0 = stb_tot; h0 = hs_cnt;
        exp_q.push_back({1'b0, 16'hBEEF});
        issue(1'b0, 16'h0003, 16'h0055, 16'h0000, acc);
        wait_hs(h0);
        chk("lkp_cyc_len", 32'(cyc_tot - c0), 32'd3);
        chk("lkp_stb_len", 32'(stb_tot - s0), 32'd1);
        chk("lkp_latency", 32'(rise_cyc - acc), 32'd5);
        chk("lkp_hold_fields", {rise_we, 15'(rise_adr), rise_key}, {1'b0, 15'h0003, 16'h0055});

        // timeout: store never answers
        ack_at = -1; store_dat = 16'hDEAD;
        r0 = rst_tot; h0 = hs_cnt;
        exp_q.push_back({1'b1, 16'h0000});
        issue(1'b1, 16'h0005, 16'h0077, 16'h9999, acc);
        wait_hs(h0);
        chk("to_reset_pulses", 32'(rst_tot - r0), 32'd1);
        chk("to_reset_time",   32'(rst_cyc - acc), 32'd66);
        chk("to_rsp_time",     32'(rise_cyc - acc), 32'd66);

        // normal command after recovery
        ack_at = 1; store_dat = 16'h0002;
        r0 = rst_tot; h0 = hs_cnt;
        exp_q.push_back({1'b0, 16'h0002});
        issue(1'b1, 16'h0000, 16'h00BB, 16'h4321, acc);
        wait_hs(h0);
        chk("post_to_latency", 32'(rise_cyc - acc), 32'd3);
        chk("post_to_no_reset", 32'(rst_tot - r0), 32'd0);

        // backpressure with a second command waiting
        ack_at = 1; store_dat = 16'h00C3;
        bus.rsp_ready_i = 1'b0; h0 = hs_cnt;
        exp_q.push_back({1'b0, 16'h00C3});
        bus.cmd_we_i = 1'b1; bus.cmd_adr_i = 16'h0006; bus.cmd_key_i = 16'h00CC; bus.cmd_dat_i = 16'h1111;
        bus.cmd_valid_i = 1'b1;
        acc = -1;
        for (int i = 0; i < 50 && acc < 0; i++) begin
            if (bus.cmd_ready_o) acc = ncyc;
            tick();
        end
        if (acc < 0) chk("bp_accept_wait", 32'd0, 32'd1);
        bus.cmd_adr_i = 16'h0007; bus.cmd_key_i = 16'h00DD; bus.cmd_dat_i = 16'h5555;
        for (int i = 0; i < 20 && !bus.rsp_valid_o; i++) tick();
        chk("bp_rsp_seen", 32'(bus.rsp_valid_o), 32'd1);
        bad_rdy = 1'b0; bad_stab = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.cmd_ready_o) bad_rdy = 1'b1;
            if (!bus.rsp_valid_o || bus.rsp_err_o || bus.rsp_dat_o != 16'h00C3) bad_stab = 1'b1;
            tick();
        end
        chk("bp_cmd_ready_low", 32'(bad_rdy), 32'd0);
        chk("bp_rsp_stable", 32'(bad_stab), 32'd0);
        exp_q.push_back({1'b0, 16'h00C3});
        bus.rsp_ready_i = 1'b1;
        acc_b = -1;
        for (int i = 0; i < 20 && acc_b < 0; i++) begin
            if (bus.cmd_ready_o) acc_b = ncyc;
            tick();
        end
        bus.cmd_valid_i = 1'b0;
        chk("bp_next_accept", 32'(acc_b - hs_cyc), 32'd1);
        wait_hs(h0 + 1);

        // ACK on the very cycle the timer reaches its limit
        ack_at = 64; store_dat = 16'h0F0F;
        r0 = rst_tot; h0 = hs_cnt;
        exp_q.push_back({1'b0, 16'h0F0F});
        issue(1'b1, 16'h0009, 16'h0011, 16'h2222, acc);
        wait_hs(h0);
        chk("col_no_reset", 32'(rst_tot - r0), 32'd0);
        chk("col_latency", 32'(rise_cyc - acc), 32'd66);

        // stray ACK while idle
        h0 = hs_cnt;
        stray_ack = 1'b1;
        repeat (4) tick();
        stray_ack = 1'b0;
        repeat (3) tick();
        chk("stray_no_rsp", 32'(hs_cnt - h0), 32'd0);
        chk("stray_idle", 32'({bus.rsp_valid_o, bus.cmd_ready_o}), 32'b01);

`ifdef KV_MASTER_STATS_EN
        chk("stat_ok", 32'(stat_ok), 32'd6);
        chk("stat_to", 32'(stat_to), 32'd1);
`endif

        // asynchronous reset in the middle of a lookup HOLD
        ack_at = -1; h0 = hs_cnt;
        issue(1'b0, 16'h0002, 16'h0033, 16'h0000, acc);
        tick();
        chk("hold_cyc_before_rst", 32'(bus.CYC_o), 32'd1);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("arst_cyc", 32'(bus.CYC_o), 32'd0);
        chk("arst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        chk("arst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
`ifdef KV_MASTER_STATS_EN
        chk("arst_stats", 32'({stat_ok, stat_to}), 32'd0);
`endif
        repeat (2) tick();
        sys_rst = 1'b0;
        repeat (6) tick();
        chk("arst_no_rsp", 32'(hs_cnt - h0), 32'd0);
        chk("arst_still_idle", 32'({bus.rsp_valid_o, bus.CYC_o}), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kv_wb_master.md
Name: kv_wb_master

Overview:
- Command sequencer directly upstream of the key-value store.
- Accepts insert, update and lookup commands from a host over a valid/ready interface.
- Converts each command into the store's bus handshake (CYC/STB/WE/ADR/DAT/KEY, ACK back), and returns the store's read data or assigned slot as a response.
- Recovers a hung store with a timeout and a one-cycle RESET pulse.

Parameters:
- DW, 16, width of key, value, address and data.
- HOLD_CYCLES, 2, cycles CYC stays high with STB low on a lookup before release (1..15).
- TIMEOUT, 64, cycles to wait for ACK before aborting (>= 4).

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  asynchronous active-high reset.
- cmd_valid_i  in  1  host command valid.
- cmd_ready_o  out  1  block can accept a command.
- cmd_we_i  in  1  1 = write (insert/update), 0 = lookup.
- cmd_adr_i  in  DW  slot address; 0 on a write means insert into the next free slot.
- cmd_key_i  in  DW  key.
- cmd_dat_i  in  DW  value to write.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  host accepts response.
- rsp_dat_o  out  DW  lookup value, or slot index returned by the store.
- rsp_err_o  out  1  1 = command timed out.
- CYC_o  out  1  bus cycle.
- STB_o  out  1  strobe.
- WE_o  out  1  write enable.
- ADR_o  out  DW  address to the store.
- DAT_o  out  DW  write data to the store.
- KEY_o  out  DW  key to the store.
- RESET_o  out  1  store recovery pulse.
- ACK_i  in  1  store acknowledge.
- DAT_i  in  DW  store read data.

Behaviour:
- Reset (async, immediate): state=IDLE, cmd_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0, CYC_o=STB_o=WE_o=RESET_o=0, ADR_o=DAT_o=KEY_o=0, timer=0.
- All outputs are registered.
- IDLE: cmd_ready_o=1. On cmd_valid_i&cmd_ready_o, capture we/adr/key/dat into ADR_o/DAT_o/KEY_o/WE_o, set CYC_o=STB_o=1, cmd_ready_o=0, go ISSUE.
- ISSUE (exactly 1 cycle): STB_o->0.
  - Write: keep CYC_o=1, go WAIT.
  - Lookup: go HOLD, load hold counter with HOLD_CYCLES.
- HOLD: CYC_o=1, STB_o=0, counter decrements each cycle. At 1, CYC_o->0, go WAIT.
- WAIT: timer increments from 0 each cycle.
  - ACK_i=1: capture DAT_i into rsp_dat_o, rsp_err_o=0, CYC_o=0, rsp_valid_o=1, go RESP.
  - Else timer==TIMEOUT-1: rsp_dat_o=0, rsp_err_o=1, CYC_o=0, RESET_o=1 for exactly one cycle, rsp_valid_o=1, go RESP.
  - ACK_i and timeout in the same cycle: ACK wins.
- RESP: hold rsp_* stable until rsp_ready_i=1, then rsp_valid_o=0, cmd_ready_o=1, go IDLE.
  - No new command is accepted while a response is pending (one outstanding transaction).
- ACK_i outside WAIT is ignored. A stray ACK never creates a response.
- ADR_o/DAT_o/KEY_o/WE_o stay constant from ISSUE through RESP.
- Minimum latency, command accept to rsp_valid_o:
  - Write: 3 cycles, with ACK in the first WAIT cycle.
  - Lookup: 3+HOLD_CYCLES cycles.
- Timer width is clog2(TIMEOUT)+1. No wrap: the timer saturates at TIMEOUT-1 and is cleared on WAIT entry.
- sys_rst mid-transaction: all outputs return to reset values asynchronously. The pending command and response are discarded.

Optional Feature:
- Macro KV_MASTER_STATS_EN.
- When defined:
  - Adds outputs stat_ok_o[DW] and stat_to_o[DW].
  - stat_ok_o counts ACKed commands; stat_to_o counts timeouts.
  - Both increment on the cycle RESP is entered, saturate at all-ones, and clear on sys_rst.
- When undefined: the ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- Insert: cmd we=1, adr=0, key=0x00AA, dat=0x1234; store model ACKs one cycle into WAIT with DAT_i=0x0001 -> CYC_o high for 2 cycles, STB_o for 1, rsp_valid_o 3 cycles after accept, rsp_dat_o=0x0001, rsp_err_o=0.
- Lookup: cmd we=0, adr=3, HOLD_CYCLES=2; store returns 0xBEEF with ACK after CYC drop -> STB_o 1 cycle, CYC_o 3 cycles, rsp_dat_o=0xBEEF.
- Timeout: store never ACKs, TIMEOUT=64 -> RESET_o pulses once exactly 64 cycles after WAIT entry, rsp_err_o=1, rsp_dat_o=0; the next command completes normally.
- Backpressure: rsp_ready_i low for 10 cycles and cmd_valid_i held high -> cmd_ready_o=0 and rsp_* stable throughout; next command is accepted the cycle after the rsp handshake.
- Collision: ACK_i asserted in the same cycle the timer reaches TIMEOUT-1 -> response has rsp_err_o=0, and RESET_o stays 0.
- Reset mid-HOLD: sys_rst asserted asynchronously -> CYC_o=0 and cmd_ready_o=1 immediately, no response issued; with KV_MASTER_STATS_EN, counters read 0.
